// File: rtl/incdec_pkg.sv
// Shared definitions for the bounded inc/dec counter: overflow policies,
// the operation code and the control decode.
package incdec_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_SAT     = 1;
  localparam int MODE_RESTART = 2;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_t;

  // load outranks inc/dec; inc and dec together cancel to a hold
  function automatic op_t decode_op(input logic enable, input logic load,
                                    input logic inc, input logic dec);
    if (!enable)       return OP_HOLD;
    if (load)          return OP_LOAD;
    if (inc && !dec)   return OP_INC;
    if (dec && !inc)   return OP_DEC;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/incdec_counter_bounded_if.sv
// Control/status bundle of the bounded counter; the controller side is the
// master, the counter itself is the slave.
interface incdec_counter_bounded_if #(parameter int width = 32);
  logic             enable;
  logic             load;
  logic             inc;
  logic             dec;
  logic [width-1:0] i0;
  logic [width-1:0] lo;
  logic [width-1:0] hi;
  logic             clr_flags;
  logic [width-1:0] o0;
  logic             at_lo;
  logic             at_hi;
  logic             ovf;
  logic             unf;
  logic             wrap_pulse;

  modport master (
    output enable, load, inc, dec, i0, lo, hi, clr_flags,
    input  o0, at_lo, at_hi, ovf, unf, wrap_pulse
  );

  modport slave (
    input  enable, load, inc, dec, i0, lo, hi, clr_flags,
    output o0, at_lo, at_hi, ovf, unf, wrap_pulse
  );
endinterface

// File: rtl/incdec_bound_step.sv
// Combinational next-count calculation for one operation, applying the
// selected overflow policy and reporting overflow/underflow events.
module incdec_bound_step
  import incdec_pkg::*;
#(
  parameter int              width   = 32,
  parameter longint unsigned countby = 1,
  parameter int              mode    = MODE_WRAP
) (
  input  op_t              op,
  input  logic [width-1:0] count,
  input  logic [width-1:0] i0,
  input  logic [width-1:0] lo,
  input  logic [width-1:0] hi,
  output logic [width-1:0] next_count,
  output logic             ovf_evt,
  output logic             unf_evt
);

  localparam logic [width-1:0] STEP = countby[width-1:0];

  logic [width:0]   sum;
  logic [width-1:0] diff;
  logic             borrow;
  logic             bounds_ok;
  logic             above_hi;
  logic             below_lo;

  always_comb begin
    sum       = {1'b0, count} + {1'b0, STEP};
    diff      = count - STEP;
    borrow    = (count < STEP);
    bounds_ok = (lo <= hi);
    above_hi  = (sum > {1'b0, hi});
    below_lo  = borrow || (diff < lo);

    next_count = count;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;

    case (op)
      OP_LOAD: begin
        // inverted bounds give no usable range, so the value goes in as-is
        if (mode == MODE_WRAP || !bounds_ok) next_count = i0;
        else if (i0 < lo)                    next_count = lo;
        else if (i0 > hi)                    next_count = hi;
        else                                 next_count = i0;
      end
      OP_INC: begin
        if (mode == MODE_WRAP) begin
          next_count = sum[width-1:0];
          ovf_evt    = sum[width];
        end else if (bounds_ok) begin
          if (above_hi) begin
            next_count = (mode == MODE_SAT) ? hi : lo;
            ovf_evt    = 1'b1;
          end else begin
            next_count = sum[width-1:0];
          end
        end
      end
      OP_DEC: begin
        if (mode == MODE_WRAP) begin
          next_count = diff;
          unf_evt    = borrow;
        end else if (bounds_ok) begin
          if (below_lo) begin
            next_count = (mode == MODE_SAT) ? lo : hi;
            unf_evt    = 1'b1;
          end else begin
            next_count = diff;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/incdec_counter_bounded.sv
// Bounded inc/dec counter: count register, sticky ovf/unf flags and a
// one-cycle wrap pulse around the combinational step logic.
module incdec_counter_bounded
  import incdec_pkg::*;
#(
  parameter int              width   = 32,
  parameter longint unsigned countby = 1,
  parameter int              mode    = MODE_WRAP
) (
  input logic                      clk,
  input logic                      reset,
  incdec_counter_bounded_if.slave  bus
);

  op_t              op;
  logic [width-1:0] count_q;
  logic [width-1:0] next_count;
  logic             ovf_evt;
  logic             unf_evt;
  logic             ovf_q;
  logic             unf_q;
  logic             wrap_q;

  assign op = decode_op(bus.enable, bus.load, bus.inc, bus.dec);

  incdec_bound_step #(
    .width   (width),
    .countby (countby),
    .mode    (mode)
  ) u_step (
    .op         (op),
    .count      (count_q),
    .i0         (bus.i0),
    .lo         (bus.lo),
    .hi         (bus.hi),
    .next_count (next_count),
    .ovf_evt    (ovf_evt),
    .unf_evt    (unf_evt)
  );

  // a fresh event outranks a coincident clear so it is never lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= next_count;
      ovf_q   <= ovf_evt | (ovf_q & ~bus.clr_flags);
      unf_q   <= unf_evt | (unf_q & ~bus.clr_flags);
      wrap_q  <= ovf_evt | unf_evt;
    end
  end

  assign bus.o0         = count_q;
  assign bus.at_lo      = (count_q == bus.lo);
  assign bus.at_hi      = (count_q == bus.hi);
  assign bus.ovf        = ovf_q;
  assign bus.unf        = unf_q;
  assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_incdec_counter_bounded.sv
// Directed bench for the bounded counter: one instance per overflow policy,
// each driven with hand-computed vectors.
module tb_incdec_counter_bounded;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  incdec_counter_bounded_if #(.width(8)) if0 ();
  incdec_counter_bounded_if #(.width(8)) if1 ();
  incdec_counter_bounded_if #(.width(8)) if2 ();

  incdec_counter_bounded #(.width(8), .countby(3), .mode(0)) dut_wrap
    (.clk(clk), .reset(reset), .bus(if0));
  incdec_counter_bounded #(.width(8), .countby(4), .mode(1)) dut_sat
    (.clk(clk), .reset(reset), .bus(if1));
  incdec_counter_bounded #(.width(8), .countby(1), .mode(2)) dut_rst
    (.clk(clk), .reset(reset), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b0;
    {if0.enable, if0.load, if0.inc, if0.dec, if0.clr_flags} = '0;
    {if1.enable, if1.load, if1.inc, if1.dec, if1.clr_flags} = '0;
    {if2.enable, if2.load, if2.inc, if2.dec, if2.clr_flags} = '0;
    if0.i0 = 8'd0; if0.lo = 8'd0; if0.hi = 8'd0;
    if1.i0 = 8'd0; if1.lo = 8'd0; if1.hi = 8'd0;
    if2.i0 = 8'd0; if2.lo = 8'd0; if2.hi = 8'd0;

    #2;
    chk("rst_o0",   if0.o0, 0);
    chk("rst_ovf",  if0.ovf, 0);
    chk("rst_unf",  if1.unf, 0);
    chk("rst_wrap", if2.wrap_pulse, 0);

    tick();
    reset = 1'b1;

    // wrap policy, countby 3
    if0.lo = 8'd254; if0.hi = 8'd1;
    if0.enable = 1; if0.load = 1; if0.i0 = 8'd254;
    tick();
    chk("m0_load", if0.o0, 254);
    if0.load = 0; if0.inc = 1;
    tick();
    chk("m0_inc_o0",   if0.o0, 1);
    chk("m0_inc_ovf",  if0.ovf, 1);
    chk("m0_inc_wrap", if0.wrap_pulse, 1);
    chk("m0_at_hi",    if0.at_hi, 1);
    if0.enable = 0;
    tick();
    chk("m0_en0_hold", if0.o0, 1);
    chk("m0_wrap_off", if0.wrap_pulse, 0);
    chk("m0_ovf_stk",  if0.ovf, 1);
    if0.enable = 1; if0.inc = 0; if0.dec = 1;
    tick();
    chk("m0_dec_o0",   if0.o0, 254);
    chk("m0_dec_unf",  if0.unf, 1);
    chk("m0_dec_wrap", if0.wrap_pulse, 1);
    chk("m0_at_lo",    if0.at_lo, 1);
    if0.dec = 0; if0.enable = 0;

    // saturate policy, countby 4, range [10,20]
    if1.lo = 8'd10; if1.hi = 8'd20;
    if1.enable = 1; if1.load = 1; if1.i0 = 8'd200;
    tick();
    chk("m1_ld_clamp", if1.o0, 20);
    chk("m1_ld_ovf",   if1.ovf, 0);
    chk("m1_ld_unf",   if1.unf, 0);
    chk("m1_ld_at_hi", if1.at_hi, 1);
    if1.i0 = 8'd18;
    tick();
    chk("m1_ld18", if1.o0, 18);
    if1.load = 0; if1.inc = 1;
    tick();
    chk("m1_inc_o0",   if1.o0, 20);
    chk("m1_inc_ovf",  if1.ovf, 1);
    chk("m1_inc_hi",   if1.at_hi, 1);
    chk("m1_inc_wrap", if1.wrap_pulse, 1);
    tick();
    chk("m1_inc2_o0",   if1.o0, 20);
    chk("m1_inc2_wrap", if1.wrap_pulse, 1);
    if1.inc = 0; if1.dec = 1;
    tick();
    chk("m1_dec1",      if1.o0, 16);
    chk("m1_dec1_wrap", if1.wrap_pulse, 0);
    tick();
    chk("m1_dec2",     if1.o0, 12);
    chk("m1_dec2_unf", if1.unf, 0);
    tick();
    chk("m1_dec3",      if1.o0, 10);
    chk("m1_dec3_unf",  if1.unf, 1);
    chk("m1_dec3_lo",   if1.at_lo, 1);
    chk("m1_dec3_wrap", if1.wrap_pulse, 1);
    if1.inc = 1;
    tick();
    chk("m1_incdec_hold", if1.o0, 10);
    chk("m1_incdec_wrap", if1.wrap_pulse, 0);
    if1.dec = 0; if1.load = 1; if1.i0 = 8'd15;
    tick();
    chk("m1_load_wins", if1.o0, 15);
    if1.load = 0; if1.inc = 0; if1.enable = 0; if1.clr_flags = 1;
    tick();
    chk("m1_clr_ovf", if1.ovf, 0);
    chk("m1_clr_unf", if1.unf, 0);
    if1.clr_flags = 0; if1.lo = 8'd30; if1.hi = 8'd20;
    if1.enable = 1; if1.inc = 1;
    tick();
    chk("m1_inv_inc",  if1.o0, 15);
    chk("m1_inv_ovf",  if1.ovf, 0);
    chk("m1_inv_wrap", if1.wrap_pulse, 0);
    if1.inc = 0; if1.dec = 1;
    tick();
    chk("m1_inv_dec",     if1.o0, 15);
    chk("m1_inv_dec_unf", if1.unf, 0);
    if1.dec = 0; if1.load = 1; if1.i0 = 8'd200;
    tick();
    chk("m1_inv_load", if1.o0, 200);
    if1.load = 0; if1.enable = 0;

    // restart policy, countby 1, range [5,9]
    if2.lo = 8'd5; if2.hi = 8'd9;
    if2.enable = 1; if2.load = 1; if2.i0 = 8'd5;
    tick();
    chk("m2_load", if2.o0, 5);
    if2.load = 0; if2.inc = 1;
    for (int v = 6; v <= 9; v++) begin
      tick();
      chk("m2_count", if2.o0, v);
    end
    chk("m2_no_ovf", if2.ovf, 0);
    tick();
    chk("m2_restart_o0",  if2.o0, 5);
    chk("m2_restart_ovf", if2.ovf, 1);
    chk("m2_restart_wr",  if2.wrap_pulse, 1);
    if2.inc = 0; if2.dec = 1;
    tick();
    chk("m2_dec_o0",  if2.o0, 9);
    chk("m2_dec_unf", if2.unf, 1);
    if2.dec = 0; if2.inc = 1; if2.clr_flags = 1;
    tick();
    chk("m2_clr_evt_o0",  if2.o0, 5);
    chk("m2_clr_evt_ovf", if2.ovf, 1);
    chk("m2_clr_evt_unf", if2.unf, 0);
    if2.inc = 0; if2.enable = 0;
    tick();
    chk("m2_clr_ovf", if2.ovf, 0);
    if2.clr_flags = 0;

    // asynchronous reset between edges, right after an overflow
    if0.enable = 1; if0.load = 1; if0.i0 = 8'd254;
    tick();
    if0.load = 0; if0.inc = 1;
    tick();
    chk("pre_rst_wrap", if0.wrap_pulse, 1);
    if0.enable = 0; if0.inc = 0;
    #2 reset = 1'b0;
    #1;
    chk("arst_o0",   if0.o0, 0);
    chk("arst_ovf",  if0.ovf, 0);
    chk("arst_unf",  if0.unf, 0);
    chk("arst_wrap", if0.wrap_pulse, 0);
    chk("arst_sat",  if1.o0, 0);
    tick();
    reset = 1'b1;
    if0.enable = 1; if0.inc = 1;
    tick();
    chk("post_rst_inc", if0.o0, 3);
    if0.enable = 0; if0.inc = 0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
